// File: rtl/dc_token_ring_fifo_din_wr.sv
// Write-side half of a dual-clock token-ring FIFO: local register bank, two-hot write token,
// synchronized and glitch-filtered read pointer for the full check, raw-pointer data mux.
module dc_token_ring_fifo_din_wr #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter logic [BUFFER_DEPTH-1:0] RP_RESET_VALUE = 'h8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    valid,
    output logic                    ready,
    output logic [BUFFER_DEPTH-1:0] write_token,
    input  logic [BUFFER_DEPTH-1:0] read_pointer,
    output logic [DATA_WIDTH-1:0]   data_async,
    output logic                    empty_wr
);

    localparam int unsigned D = BUFFER_DEPTH;
    localparam logic [D-1:0] TOKEN_RESET = D'(12);

    logic [DATA_WIDTH-1:0] buffer [D];
    logic [D-1:0]          rp_sync1;
    logic [D-1:0]          rp_sync2;
    logic [D-1:0]          rp_hold;
    logic [D-1:0]          write_pointer;
    logic [D-1:0]          wp_plus1;
    logic [D-1:0]          wp_plus2;
    logic                  full;
    logic                  write_enable;

    // Exactly one bit set; zero and multi-hot samples are reader-token transients.
    function automatic logic is_onehot(input logic [D-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Write pointer is the upper hot bit of the two-hot token; also derive slots W+1, W+2.
    always_comb begin
        write_pointer = write_token & {write_token[D-2:0], write_token[D-1]};
        wp_plus1      = {write_pointer[D-2:0], write_pointer[D-1]};
        wp_plus2      = {write_pointer[D-3:0], write_pointer[D-1:D-2]};
    end

    // Full when the filtered read pointer sits one or two slots ahead of the write slot;
    // the two-slot margin absorbs the synchronizer lag.
    always_comb begin
        full         = |(rp_hold & (wp_plus1 | wp_plus2));
        ready        = ~full;
        empty_wr     = |(rp_hold & write_pointer);
        write_enable = valid & ready;
    end

    // Token rotates left by one slot on every accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_token <= TOKEN_RESET;
        end else if (write_enable) begin
            write_token <= {write_token[D-2:0], write_token[D-1]};
        end
    end

    // Store the payload into the slot addressed by the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                if (write_enable && write_pointer[i]) begin
                    buffer[i] <= data;
                end
            end
        end
    end

    // Two-flop synchronizer, then a hold register that only accepts clean one-hot values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_sync1 <= RP_RESET_VALUE;
            rp_sync2 <= RP_RESET_VALUE;
            rp_hold  <= RP_RESET_VALUE;
        end else begin
            rp_sync1 <= read_pointer;
            rp_sync2 <= rp_sync1;
            if (is_onehot(rp_sync2)) begin
                rp_hold <= rp_sync2;
            end
        end
    end

    // Unregistered read mux on the raw pointer; the reader samples it only when it is valid.
    always_comb begin
        data_async = '0;
        for (int i = 0; i < D; i++) begin
            if (read_pointer[i]) begin
                data_async = data_async | buffer[i];
            end
        end
    end

endmodule

// File: tb/tb_dc_token_ring_fifo_din_wr.sv
// Randomized bench for the FIFO write half against an index-arithmetic reference model.
module tb_dc_token_ring_fifo_din_wr;

    localparam int DW = 10;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic [D-1:0]  write_token;
    logic [D-1:0]  read_pointer = 8'h08;
    logic [DW-1:0] data_async;
    logic          empty_wr;

    int checks = 0;
    int errors = 0;

    // Reference model: write slot index, filtered read slot index, storage, pointer history.
    int            m_w;
    int            m_r;
    logic [DW-1:0] m_mem [D];
    logic [D-1:0]  m_hist [$];

    dc_token_ring_fifo_din_wr #(
        .DATA_WIDTH     (DW),
        .BUFFER_DEPTH   (D),
        .RP_RESET_VALUE (8'h08)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .write_token  (write_token),
        .read_pointer (read_pointer),
        .data_async   (data_async),
        .empty_wr     (empty_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [D-1:0] exp_token();
        logic [D-1:0] t;
        t = '0;
        t[m_w] = 1'b1;
        t[(m_w + D - 1) % D] = 1'b1;
        return t;
    endfunction

    function automatic logic exp_ready();
        return ((m_w - m_r + D) % D) < (D - 2);
    endfunction

    function automatic logic [DW-1:0] exp_dout(input logic [D-1:0] rp);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) if (rp[i]) r = r | m_mem[i];
        return r;
    endfunction

    function automatic void model_reset();
        m_w = 3;
        m_r = 3;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_hist = {8'h08, 8'h08};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_tok"}, 32'(write_token), 32'(exp_token()));
        check({tag, "_rdy"}, 32'(ready), 32'(exp_ready()));
        check({tag, "_emp"}, 32'(empty_wr), 32'(m_w == m_r));
        check({tag, "_dout"}, 32'(data_async), 32'(exp_dout(read_pointer)));
    endtask

    // One clock cycle: apply inputs at negedge, check before the edge, advance the model.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [D-1:0] rp);
        logic         we;
        logic [D-1:0] old;
        int           cnt;
        int           idx;
        valid = v;
        data = d;
        read_pointer = rp;
        #1;
        check_outputs(tag);
        we = v && exp_ready();
        @(posedge clk);
        if (we) begin
            m_mem[m_w] = d;
            m_w = (m_w + 1) % D;
        end
        old = m_hist.pop_front();
        cnt = 0;
        idx = 0;
        for (int i = 0; i < D; i++) if (old[i]) begin cnt++; idx = i; end
        if (cnt == 1) m_r = idx;
        m_hist.push_back(rp);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must settle with no clock.
    task automatic do_reset(input string tag);
        read_pointer = 8'h08;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_tok"}, 32'(write_token), 32'h0C);
        check({tag, "_rdy"}, 32'(ready), 32'h1);
        check({tag, "_emp"}, 32'(empty_wr), 32'h1);
        check({tag, "_dout"}, 32'(data_async), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [D-1:0] rp;
        int           sel;
        @(negedge clk);
        do_reset("rst0");

        // Fill: six writes reach the two-slot margin, token parks at 'h3.
        for (int i = 0; i < 10; i++) cycle("fill", 1'b1, DW'($urandom), 8'h08);
        check("fill_token", 32'(write_token), 32'h03);
        check("fill_ready", 32'(ready), 32'h0);

        // Drain release: ready returns after three edges, next write goes to slot 1.
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0, DW'($urandom), 8'h10);
        check("drain_ready", 32'(ready), 32'h1);
        cycle("drain_wr", 1'b1, DW'($urandom), 8'h10);
        check("drain_token", 32'(write_token), 32'h06);

        // Data path through the raw read pointer.
        do_reset("rst1");
        cycle("dp0", 1'b1, 10'h2A5, 8'h08);
        cycle("dp1", 1'b1, 10'h15A, 8'h08);
        cycle("dp2", 1'b0, 10'h000, 8'h08);
        check("dp_first", 32'(data_async), 32'h2A5);
        read_pointer = 8'h10;
        #1;
        check("dp_second", 32'(data_async), 32'h15A);

        // Glitch filter: zero and multi-hot samples must not move the held pointer.
        do_reset("rst2");
        for (int i = 0; i < 6; i++) cycle("gf_fill", 1'b1, DW'($urandom), 8'h08);
        cycle("gf_zero", 1'b1, DW'($urandom), 8'h00);
        cycle("gf_multi", 1'b1, DW'($urandom), 8'h18);
        for (int i = 0; i < 4; i++) cycle("gf_back", 1'b1, DW'($urandom), 8'h08);
        check("gf_ready", 32'(ready), 32'h0);
        check("gf_token", 32'(write_token), 32'h03);

        // Wrap: reader trails one slot behind, token returns to 'hC every 8 writes.
        do_reset("rst3");
        for (int i = 0; i < 20; i++) begin
            rp = (i == 0) ? 8'h08 : 8'(1 << ((m_w + D - 1) % D));
            cycle("wrap", 1'b1, DW'($urandom), rp);
            if (i == 7 || i == 15) check("wrap_token", 32'(write_token), 32'h0C);
        end

        // Random traffic with occasional glitchy pointers and a mid-burst reset.
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset("rst_mid");
            sel = $urandom_range(0, 11);
            if (sel < D) rp = 8'(1 << sel);
            else if (sel == 8) rp = 8'h00;
            else if (sel == 9) rp = 8'($urandom);
            else rp = read_pointer;
            cycle("rand", 1'($urandom_range(0, 3) != 0), DW'($urandom), rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_token_ring_fifo_din_wr.md
Name: dc_token_ring_fifo_din_wr

Overview:
- Write-side (source clock domain) half of the dual-clock token-ring FIFO.
- Accepts data through a valid/ready handshake and stores it in a local register bank.
- Exports the two-hot write token to the read-side half, which synchronizes it for empty detection.
- Takes the reader's one-hot read pointer asynchronously. The raw pointer selects the exported data word; a synchronized, filtered copy drives the full check.

Parameters:
- DATA_WIDTH, 10, payload width in bits.
- BUFFER_DEPTH, 8, number of storage slots; must be >= 6.
- RP_RESET_VALUE, 'h8, reset value of the read-pointer synchronizer and hold register. Matches the reader's read_pointer after reset.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous reset, active-high.
- data  input  DATA_WIDTH  write payload.
- valid  input  1  payload valid.
- ready  output  1  space available; a write occurs when valid & ready.
- write_token  output  BUFFER_DEPTH  registered two-hot write token, sent to the read domain.
- read_pointer  input  BUFFER_DEPTH  one-hot read slot from the read domain (asynchronous).
- data_async  output  DATA_WIDTH  buffer word selected by the raw read_pointer.
- empty_wr  output  1  write-domain view of empty, for clock gating and status only.

Behaviour:
- Reset (async, rst=1):
  - write_token = 'hC (bits 2,3).
  - All buffer words = 0.
  - Both synchronizer flops = RP_RESET_VALUE; rp_hold = RP_RESET_VALUE.
  - Resulting outputs: ready=1, empty_wr=1, data_async = buffer[read_pointer] = 0.
- Write pointer (combinational): write_pointer[k] = write_token[k] & write_token[(k-1) mod D]. This is the upper hot bit of the token. Reset value 'h8, so the first write lands in slot 3.
- write_enable = valid & ready.
- On a write_enable clock edge:
  - buffer[W] <= data, where W is the index of write_pointer.
  - write_token rotates left by 1, with bit D-1 wrapping to bit 0.
  - No other state changes.
- valid without ready: no write; token and buffer unchanged. data may change freely while valid=0.
- Read-pointer sync: 2-flop synchronizer on read_pointer, followed by the rp_hold register.
  - rp_hold loads the second flop's output only when that output is exactly one-hot.
  - Zero or multi-hot values (transients while the reader's token moves) are ignored; rp_hold keeps its previous value.
- Occupancy = (W - R) mod D, where R is the index of rp_hold.
- full when occupancy >= D-2, i.e. rp_hold has a bit at slot W+1 or W+2 (mod D).
  - Usable capacity is D-2; the 2-slot margin covers the stale synchronized pointer.
- ready = ~full. It depends only on registered state, never on valid (no combinational valid->ready path).
- empty_wr = (W == R).
- data_async = OR over i of (buffer[i] AND read_pointer[i]), using the raw input.
  - No registers in this path; the reader samples it only when its own valid is asserted.
  - read_pointer = 0 gives data_async = 0.
  - Multi-hot read_pointer gives the bitwise OR of the selected words (don't-care for the reader).
- Latency:
  - Write-to-token: write_token changes on the same edge that captures the data.
  - Reader-advance-to-ready: ready rises on the third clk edge after read_pointer changes (2 sync flops plus rp_hold).
- Wrap-around: token and pointer rotate modulo D with no special case.
- Simultaneous write and reader advance: full is evaluated on the pre-edge rp_hold. A write is accepted only if ready was already high.
- Reset mid-operation: all state returns to reset values immediately; buffered data is lost. The reader must be reset together with this block.

Test Plan:
- Reset: assert rst mid-burst -> write_token='hC, ready=1, empty_wr=1, data_async=0 immediately, with no clock edge required.
- Fill, with read_pointer held at 'h8 and valid=1 for 10 cycles -> exactly 6 writes (slots 3,4,5,6,7,0). Then ready=0 and write_token='h3. Token stays at 'h3 for the remaining cycles.
- Drain release: from full, change read_pointer 'h8 -> 'h10 -> ready=1 on the 3rd clk edge after the change. The next write goes to slot 1 and write_token becomes 'h6.
- Data path: write 'h2A5 first and 'h15A second, with read_pointer='h8 -> data_async='h2A5. Set read_pointer='h10 -> data_async='h15A combinationally.
- Glitch filter: from full, pulse read_pointer to 'h0 for one cycle, then 'h18 for one cycle, then back to 'h8 -> rp_hold stays 'h8 and ready stays 0 throughout.
- Wrap: 20 writes with read_pointer tracking one slot behind each write -> write_token returns to 'hC after every 8 writes and ready never drops.
